// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm control path: duty width default, duty ceiling and control FSM states.
// Pure declarations; no logic, no latency.
package pwm_pkg;

    localparam int DUTY_W_DEF = 4;
    localparam logic [DUTY_W_DEF-1:0] DUTY_MAX = {DUTY_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } ctrl_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> debounced level -> registered rising-edge press pulse.
// A stable change is accepted after DEBOUNCE_CYC agreeing samples; no backpressure.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prv_q, level_prv_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        cnt_d       = '0;
        level_d     = level_q;
        // Any disagreeing sample run shorter than DEBOUNCE_CYC is thrown away.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_prv_d = level_q;
        press_d     = level_q & ~level_prv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_prv_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_prv_q <= level_prv_d;
            press_q     <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Up/down buttons -> saturating duty word, manual stepping or prescaled ramp mode.
// Duty moves DEBOUNCE_CYC+3 edges after a button is first sampled high; no backpressure.
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int DEBOUNCE_CYC = 16,
    parameter int RAMP_DIV     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              mode_ramp,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              at_max,
    output logic              at_min
);

    localparam logic [DUTY_W-1:0] DMAX = {DUTY_W{1'b1}};
    localparam int PS_W = cnt_width(RAMP_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RAMP_DIV - 1);

    logic up_p, dn_p;
    logic up_level_unused, dn_level_unused;

    ctrl_state_e       state_q, state_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_upd_q, duty_upd_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .level   (up_level_unused),
        .press   (up_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_dn),
        .level   (dn_level_unused),
        .press   (dn_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A ramp parks in IDLE as soon as it sits on its limit, so entering at the limit exits next cycle.
    always_comb begin
        state_d = state_q;
        if (!mode_ramp) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (up_p && !dn_p)      state_d = RAMP_UP;
                    else if (dn_p && !up_p) state_d = RAMP_DN;
                end
                RAMP_UP: begin
                    if (up_p)                state_d = IDLE;
                    else if (dn_p)           state_d = RAMP_DN;
                    else if (duty_q == DMAX) state_d = IDLE;
                end
                RAMP_DN: begin
                    if (dn_p)              state_d = IDLE;
                    else if (up_p)         state_d = RAMP_UP;
                    else if (duty_q == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Prescaler rests at zero outside a ramp and whenever a press lands, so every entry starts fresh.
    always_comb begin
        duty_d  = duty_q;
        presc_d = '0;
        if (!mode_ramp) begin
            if (up_p && !dn_p && duty_q != DMAX)      duty_d = duty_q + 1'b1;
            else if (dn_p && !up_p && duty_q != '0)   duty_d = duty_q - 1'b1;
        end else begin
            case (state_q)
                RAMP_UP: begin
                    if (!up_p && !dn_p && duty_q != DMAX) begin
                        if (presc_q == PS_LAST) duty_d  = duty_q + 1'b1;
                        else                    presc_d = presc_q + 1'b1;
                    end
                end
                RAMP_DN: begin
                    if (!up_p && !dn_p && duty_q != '0) begin
                        if (presc_q == PS_LAST) duty_d  = duty_q - 1'b1;
                        else                    presc_d = presc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        duty_upd_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            duty_q     <= '0;
            duty_upd_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            duty_q     <= duty_d;
            duty_upd_q <= duty_upd_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = duty_upd_q;
    assign at_max   = (duty_q == DMAX);
    assign at_min   = (duty_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl with DEBOUNCE_CYC=4, RAMP_DIV=8: scenario tasks plus a duty scoreboard.
module tb_pwm_duty_ctrl;
    import pwm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic       mode_ramp = 1'b0;
    logic [3:0] duty;
    logic       duty_upd;
    logic       at_max;
    logic       at_min;

    int         assertions = 0;
    int         failures = 0;
    int         upd_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;

    pwm_duty_ctrl #(.DUTY_W(4), .DEBOUNCE_CYC(4), .RAMP_DIV(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .mode_ramp (mode_ramp),
        .duty      (duty),
        .duty_upd  (duty_upd),
        .at_max    (at_max),
        .at_min    (at_min)
    );

    always #5 clk = ~clk;

    // Every update pulse pops the next expected duty value.
    always @(negedge clk) begin
        if (rst_n && duty_upd) begin
            upd_cnt++;
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected_upd: duty=%0d, no update expected", duty);
            end else begin
                exp_v = exp_q.pop_front();
                if (duty !== exp_v) begin
                    failures++;
                    $display("FAIL scoreboard_duty: got %0d, expected %0d", duty, exp_v);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic press(input bit up, input bit dn);
        btn_up = up;
        btn_dn = dn;
        tick(9);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        int u0;
        rst_n = 1'b0;
        mode_ramp = 1'b0;
        tick(3);
        assertions++;
        if (duty !== 4'd0) begin failures++; $display("FAIL reset_duty: got %0d, expected 0", duty); end
        assertions++;
        if (at_min !== 1'b1) begin failures++; $display("FAIL reset_at_min: got %b, expected 1", at_min); end
        assertions++;
        if (at_max !== 1'b0) begin failures++; $display("FAIL reset_at_max: got %b, expected 0", at_max); end
        assertions++;
        if (duty_upd !== 1'b0) begin failures++; $display("FAIL reset_duty_upd: got %b, expected 0", duty_upd); end
        rst_n = 1'b1;
        u0 = upd_cnt;
        tick(20);
        assertions++;
        if (duty !== 4'd0) begin failures++; $display("FAIL idle_duty: got %0d, expected 0", duty); end
        assertions++;
        if (upd_cnt !== u0) begin failures++; $display("FAIL idle_no_upd: got %0d pulses, expected 0", upd_cnt - u0); end
    endtask

    task automatic test_debounce();
        int u0;
        int early;
        u0 = upd_cnt;
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        tick(15);
        assertions++;
        if (duty !== 4'd0 || upd_cnt !== u0) begin
            failures++;
            $display("FAIL glitch_ignored: duty=%0d pulses=%0d, expected duty 0 and no pulse", duty, upd_cnt - u0);
        end
        exp_q.push_back(4'd1);
        btn_up = 1'b1;
        early = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (i < 8 && duty !== 4'd0) early++;
            if (i == 8) begin
                assertions++;
                if (duty !== 4'd1 || duty_upd !== 1'b1) begin
                    failures++;
                    $display("FAIL debounce_latency: duty=%0d upd=%b at edge 8, expected 1 and 1", duty, duty_upd);
                end
            end
        end
        assertions++;
        if (early !== 0) begin failures++; $display("FAIL debounce_early: %0d early changes, expected 0", early); end
        tick(2);
        btn_up = 1'b0;
        tick(12);
        assertions++;
        if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL debounce_one_pulse: got %0d pulses, expected 1", upd_cnt - u0); end
    endtask

    task automatic test_manual();
        int u0;
        int m;
        do_reset();
        mode_ramp = 1'b0;
        u0 = upd_cnt;
        m = 0;
        for (int i = 0; i < 16; i++) begin
            if (m < 15) begin
                m++;
                exp_q.push_back(4'(m));
            end
            press(1'b1, 1'b0);
        end
        assertions++;
        if (duty !== 4'd15 || at_max !== 1'b1 || at_min !== 1'b0) begin
            failures++;
            $display("FAIL manual_max: duty=%0d at_max=%b at_min=%b, expected 15 1 0", duty, at_max, at_min);
        end
        assertions++;
        if (upd_cnt - u0 !== 15) begin failures++; $display("FAIL manual_sat_pulses: got %0d, expected 15", upd_cnt - u0); end
        exp_q.push_back(4'd14);
        press(1'b0, 1'b1);
        assertions++;
        if (duty !== 4'd14 || at_max !== 1'b0) begin failures++; $display("FAIL manual_dn: duty=%0d at_max=%b, expected 14 0", duty, at_max); end
        u0 = upd_cnt;
        press(1'b1, 1'b1);
        assertions++;
        if (duty !== 4'd14 || upd_cnt !== u0) begin failures++; $display("FAIL manual_both: duty=%0d pulses=%0d, expected 14 0", duty, upd_cnt - u0); end
    endtask

    task automatic test_ramp_full();
        int times[$];
        int bad;
        int u0;
        do_reset();
        mode_ramp = 1'b1;
        for (int v = 1; v <= 15; v++) exp_q.push_back(4'(v));
        btn_up = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick(1);
            if (c == 9) btn_up = 1'b0;
            if (duty_upd) times.push_back(c);
        end
        assertions++;
        if (times.size() !== 15) begin failures++; $display("FAIL ramp_pulse_count: got %0d, expected 15", times.size()); end
        assertions++;
        if (times.size() == 0 || times[0] !== 16) begin
            failures++;
            $display("FAIL ramp_first_step: got edge %0d, expected 16", (times.size() == 0) ? -1 : times[0]);
        end
        bad = 0;
        for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] !== 8) bad++;
        assertions++;
        if (bad !== 0) begin failures++; $display("FAIL ramp_spacing: %0d gaps differ, expected all 8", bad); end
        assertions++;
        if (duty !== 4'd15 || at_max !== 1'b1 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL ramp_end: duty=%0d at_max=%b state=%0d, expected 15 1 IDLE", duty, at_max, dut.state_q);
        end
        assertions++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL ramp_sb_drain: %0d left, expected 0", exp_q.size()); end
        u0 = upd_cnt;
        press(1'b1, 1'b0);
        tick(5);
        assertions++;
        if (duty !== 4'd15 || upd_cnt !== u0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL ramp_at_limit: duty=%0d pulses=%0d state=%0d, expected 15 0 IDLE", duty, upd_cnt - u0, dut.state_q);
        end
    endtask

    task automatic test_ramp_reverse();
        int u0;
        do_reset();
        mode_ramp = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            exp_q.push_back(4'(v));
            press(1'b1, 1'b0);
        end
        mode_ramp = 1'b1;
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd3);
        btn_up = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if (c == 1)  btn_dn = 1'b1;
            if (c == 9)  btn_up = 1'b0;
            if (c == 10) btn_dn = 1'b0;
            if (c == 19) btn_dn = 1'b1;
            if (c == 29) btn_dn = 1'b0;
            if (c == 16) begin
                assertions++;
                if (duty !== 4'd5) begin failures++; $display("FAIL reverse_hold: got %0d at edge 16, expected 5", duty); end
            end
            if (c == 17) begin
                assertions++;
                if (duty !== 4'd4) begin failures++; $display("FAIL reverse_step: got %0d at edge 17, expected 4", duty); end
            end
            if (c == 27) begin
                assertions++;
                if (dut.state_q !== IDLE) begin failures++; $display("FAIL reverse_stop_state: got %0d at edge 27, expected IDLE", dut.state_q); end
            end
        end
        assertions++;
        if (duty !== 4'd3 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL reverse_final: duty=%0d pending=%0d, expected 3 0", duty, exp_q.size());
        end
        u0 = upd_cnt;
        press(1'b1, 1'b1);
        tick(3);
        assertions++;
        if (duty !== 4'd3 || upd_cnt !== u0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL ramp_both: duty=%0d pulses=%0d state=%0d, expected 3 0 IDLE", duty, upd_cnt - u0, dut.state_q);
        end
    endtask

    task automatic test_reset_midramp();
        bit found;
        int u0;
        do_reset();
        mode_ramp = 1'b1;
        for (int v = 1; v <= 9; v++) exp_q.push_back(4'(v));
        found = 1'b0;
        btn_up = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick(1);
            if (c == 9) btn_up = 1'b0;
            if (duty === 4'd9) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (!found) begin failures++; $display("FAIL midramp_reach9: duty=%0d, expected to reach 9", duty); end
        rst_n = 1'b0;
        mode_ramp = 1'b0;
        btn_up = 1'b1;
        #1;
        assertions++;
        if (duty !== 4'd0 || at_min !== 1'b1 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL async_reset: duty=%0d at_min=%b state=%0d, expected 0 1 IDLE", duty, at_min, dut.state_q);
        end
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        exp_q.push_back(4'd1);
        u0 = upd_cnt;
        tick(30);
        btn_up = 1'b0;
        tick(12);
        assertions++;
        if (duty !== 4'd1 || upd_cnt - u0 !== 1) begin
            failures++;
            $display("FAIL held_after_reset: duty=%0d pulses=%0d, expected 1 1", duty, upd_cnt - u0);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_manual();
        test_ramp_full();
        test_ramp_reverse();
        test_reset_midramp();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
